irda_rx_demod: RTL and testbench

// - IrDA SIR receive front end, directly upstream of the receiver controller and its shift register.
// - Demodulates raw IR pulses (~3/16-bit, active-low from the transceiver) into NRZ bits.
// - Drives the controller: start on a validated start-bit pulse, then baud_rxir once per bit window with rx_bit valid.
// - Frame is 10 windows: start, 8 data LSB-first, stop; IrDA rule: pulse in window = 0, no pulse = 1.

---
 rtl/irda_pkg.sv | 18 +
 rtl/irda_pulse_filter.sv | 53 +++++
 rtl/irda_rx_demod.sv | 127 ++++++++++++
 tb/tb_irda_rx_demod.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irda_pkg.sv
// Shared constants and state encoding for the IrDA SIR receive path.
// Used by the demodulator front end and the receiver controller.
package irda_pkg;

   // Demodulator FSM states
   typedef enum logic {
      IDLE  = 1'b0,
      FRAME = 1'b1
   } state_e;

   // 50 MHz clock / 9600 baud
   localparam int unsigned DEF_CLKS_PER_BIT = 5208;
   // Glitch filter: consecutive synchronized-low cycles needed to accept a pulse
   localparam int unsigned DEF_MIN_PULSE    = 4;
   // Windows per frame: start, 8 data bits LSB-first, stop
   localparam int unsigned FRAME_BITS       = 10;

endpackage : irda_pkg

// File: rtl/irda_pulse_filter.sv
// Synchronizer, glitch filter and falling-edge qualifier for the raw IR input.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   ir_n_i     in   raw asynchronous IR receiver output, active-low pulse
//   pulse_ok_o out  one-cycle strobe on the MIN_PULSE-th consecutive low
//                   cycle of the synchronized line, once per falling edge
module irda_pulse_filter
   import irda_pkg::*;
#(
   parameter int unsigned MIN_PULSE = DEF_MIN_PULSE
) (
   input  logic clk,
   input  logic rst,
   input  logic ir_n_i,
   output logic pulse_ok_o
);

   localparam int unsigned          CNT_W   = $clog2(MIN_PULSE + 1);
   localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MIN_PULSE);
   localparam logic [CNT_W-1:0]     CNT_HIT = CNT_W'(MIN_PULSE - 1);

   logic             sync1_q;
   logic             ir_s_q;
   logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;

   // Two-flop synchronizer plus low-run counter; line idles high out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b1;
         ir_s_q   <= 1'b1;
         lo_cnt_q <= '0;
      end else begin
         sync1_q  <= ir_n_i;
         ir_s_q   <= sync1_q;
         lo_cnt_q <= lo_cnt_d;
      end
   end

   // lo_cnt_q holds the number of low cycles before this one, saturating at
   // MIN_PULSE so a stuck-low line produces exactly one strobe.
   always_comb begin
      lo_cnt_d = lo_cnt_q;
      if (ir_s_q) begin
         lo_cnt_d = '0;
      end else if (lo_cnt_q != CNT_MAX) begin
         lo_cnt_d = lo_cnt_q + CNT_W'(1);
      end
   end

   assign pulse_ok_o = ~ir_s_q && (lo_cnt_q == CNT_HIT);

endmodule : irda_pulse_filter

// File: rtl/irda_rx_demod.sv
// IrDA SIR receive demodulator: turns filtered IR pulses into NRZ bits with
// one strobe per bit window (pulse in window = 0, no pulse = 1).
// Ports:
//   clk        in   clock, all state on posedge
//   rst        in   synchronous active-high reset
//   ena        in   block enable; low returns the FSM to IDLE
//   ir_n       in   raw asynchronous IR receiver output, active-low pulse
//   start      out  one-cycle strobe: start-bit pulse accepted
//   baud_rxir  out  one-cycle strobe at the end of each bit window
//   rx_bit     out  decoded bit for the window just closed (held between ticks)
//   frame_err  out  strobe with the stop-window tick when that window saw a pulse
//   busy       out  high from the start strobe through the last tick
module irda_rx_demod
   import irda_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int unsigned MIN_PULSE    = DEF_MIN_PULSE
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   input  logic ir_n,
   output logic start,
   output logic baud_rxir,
   output logic rx_bit,
   output logic frame_err,
   output logic busy
);

   localparam int unsigned        BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam int unsigned        BIT_W     = $clog2(FRAME_BITS);
   localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0]  BAUD_LOAD = BAUD_W'(MIN_PULSE);
   localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(FRAME_BITS - 1);

   state_e            state_q,      state_d;
   logic [BAUD_W-1:0] baud_cnt_q,   baud_cnt_d;
   logic [BIT_W-1:0]  bit_cnt_q,    bit_cnt_d;
   logic              pulse_seen_q, pulse_seen_d;
   logic              rx_bit_q,     rx_bit_d;
   logic              pulse_ok;

   irda_pulse_filter #(
      .MIN_PULSE (MIN_PULSE)
   ) u_filter (
      .clk        (clk),
      .rst        (rst),
      .ir_n_i     (ir_n),
      .pulse_ok_o (pulse_ok)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         baud_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         pulse_seen_q <= 1'b0;
         rx_bit_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         baud_cnt_q   <= baud_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         pulse_seen_q <= pulse_seen_d;
         rx_bit_q     <= rx_bit_d;
      end
   end

   // Next-state and strobes. Acceptance happens MIN_PULSE-1 cycles after the
   // line first went low, so baud_cnt is preloaded to put the window origin
   // on that first low cycle.
   always_comb begin
      state_d      = state_q;
      baud_cnt_d   = baud_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      pulse_seen_d = pulse_seen_q;
      rx_bit_d     = rx_bit_q;
      start        = 1'b0;
      baud_rxir    = 1'b0;
      frame_err    = 1'b0;
      rx_bit       = rx_bit_q;
      busy         = (state_q == FRAME);

      if (!ena) begin
         state_d      = IDLE;
         baud_cnt_d   = '0;
         bit_cnt_d    = '0;
         pulse_seen_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pulse_ok) begin
                  start        = 1'b1;
                  busy         = 1'b1;
                  state_d      = FRAME;
                  baud_cnt_d   = BAUD_LOAD;
                  bit_cnt_d    = '0;
                  pulse_seen_d = 1'b1;
               end
            end
            FRAME: begin
               baud_cnt_d = baud_cnt_q + BAUD_W'(1);
               if (pulse_ok) begin
                  pulse_seen_d = 1'b1;
               end
               if (baud_cnt_q == BAUD_LAST) begin
                  // A pulse landing on the tick belongs to the next window
                  baud_rxir    = 1'b1;
                  rx_bit       = ~pulse_seen_q;
                  rx_bit_d     = ~pulse_seen_q;
                  baud_cnt_d   = '0;
                  pulse_seen_d = pulse_ok;
                  bit_cnt_d    = bit_cnt_q + BIT_W'(1);
                  if (bit_cnt_q == BIT_LAST) begin
                     frame_err    = pulse_seen_q;
                     state_d      = IDLE;
                     bit_cnt_d    = '0;
                     pulse_seen_d = 1'b0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule : irda_rx_demod

// File: tb/tb_irda_rx_demod.sv
// Bench for irda_rx_demod with CLKS_PER_BIT=16, MIN_PULSE=2.
module tb_irda_rx_demod;
   import irda_pkg::*;

   localparam int CPB  = 16;
   localparam int MP   = 2;
   localparam int NB   = FRAME_BITS;
   localparam int HMAX = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ena = 1'b0;
   logic ir_n = 1'b1;
   logic start, baud_rxir, rx_bit, frame_err, busy;

   irda_rx_demod #(.CLKS_PER_BIT(CPB), .MIN_PULSE(MP)) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .ir_n      (ir_n),
      .start     (start),
      .baud_rxir (baud_rxir),
      .rx_bit    (rx_bit),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Observed events
   int q_start[$];
   int q_tick[$];
   int q_ferr[$];
   int q_fall[$];
   bit q_bit[$];

   task automatic clear_q();
      q_start.delete(); q_tick.delete(); q_ferr.delete();
      q_fall.delete();  q_bit.delete();
   endtask

   // Model: time-based windows anchored at T0, acceptance from run-lengths
   bit irn_h [HMAX];
   bit rst_h [HMAX];
   bit irs_h [HMAX];
   bit m_active  = 1'b0;
   int m_t0      = 0;
   int m_kn      = 0;
   bit m_pw [NB];
   bit m_last_rx = 1'b0;
   bit prev_busy = 1'b0;

   initial begin : compare
      int t, w;
      bit irs, acc, e_start, e_tick, e_rx, e_ferr, e_busy;
      forever begin
         @(negedge clk);
         #2;
         t = cyc;
         irn_h[t] = ir_n;
         rst_h[t] = rst;
         irs = 1'b1;
         if (t >= 2 && !rst_h[t-1] && !rst_h[t-2]) irs = irn_h[t-2];
         irs_h[t] = irs;
         acc = (t > MP);
         if (acc) begin
            for (int j = 0; j < MP; j++) if (irs_h[t-j]) acc = 1'b0;
            if (!irs_h[t-MP]) acc = 1'b0;
         end
         e_start = ena && !m_active && acc;
         e_tick  = ena && m_active && (t == m_t0 + (m_kn + 1) * CPB - 1);
         e_rx    = e_tick ? !m_pw[m_kn] : m_last_rx;
         e_ferr  = e_tick && (m_kn == NB - 1) && m_pw[NB-1];
         e_busy  = m_active || e_start;
         chk($sformatf("start@%0d", t),     start,     e_start);
         chk($sformatf("baud_rxir@%0d", t), baud_rxir, e_tick);
         chk($sformatf("rx_bit@%0d", t),    rx_bit,    e_rx);
         chk($sformatf("frame_err@%0d", t), frame_err, e_ferr);
         chk($sformatf("busy@%0d", t),      busy,      e_busy);
         if (start === 1'b1) q_start.push_back(t);
         if (baud_rxir === 1'b1) begin
            q_tick.push_back(t);
            q_bit.push_back(rx_bit);
         end
         if (frame_err === 1'b1) q_ferr.push_back(t);
         if (prev_busy && busy === 1'b0) q_fall.push_back(t);
         prev_busy = (busy === 1'b1);
         if (rst) begin
            m_active  = 1'b0;
            m_last_rx = 1'b0;
         end else if (!ena) begin
            m_active = 1'b0;
         end else if (e_start) begin
            m_active = 1'b1;
            m_t0     = t - (MP - 1);
            m_kn     = 0;
            for (int k = 0; k < NB; k++) m_pw[k] = 1'b0;
            m_pw[0]  = 1'b1;
         end else if (m_active) begin
            if (acc) begin
               w = (t - m_t0 + 1) / CPB;
               if (w < NB) m_pw[w] = 1'b1;
            end
            if (e_tick) begin
               m_last_rx = e_rx;
               m_kn++;
               if (m_kn == NB) m_active = 1'b0;
            end
         end
      end
   end

   // Stimulus waveform, one entry per cycle (1 = line idle)
   bit wave [512];

   task automatic wave_clear();
      for (int i = 0; i < 512; i++) wave[i] = 1'b1;
   endtask

   task automatic wave_pulse(input int s, input int len);
      for (int i = s; i < s + len; i++) wave[i] = 1'b0;
   endtask

   task automatic wave_frame(input int base, input logic [7:0] b, input bit stop_pulse);
      bit bits [NB];
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = b[i];
      bits[NB-1] = !stop_pulse;
      for (int k = 0; k < NB; k++) if (!bits[k]) wave_pulse(base + k * CPB, 3);
   endtask

   task automatic play(input int len, input int rst_at, input int ena_lo, input int ena_len,
                       output int c0);
      c0 = 0;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         ir_n = wave[i];
         rst  = (i == rst_at);
         ena  = !(i >= ena_lo && i < ena_lo + ena_len);
         if (i == 0) c0 = cyc;
      end
   endtask

   // Literal expectations for a lone frame whose first ir_n low is cycle c0
   task automatic check_frame(input string nm, input int c0, input logic [7:0] exp_byte,
                              input bit exp_stop, input bit exp_ferr);
      int t0;
      logic [7:0] b;
      t0 = c0 + 2;
      chk({nm, "_nstart"}, q_start.size(), 1);
      if (q_start.size() > 0) chk({nm, "_tstart"}, q_start[0], t0 + 1);
      chk({nm, "_nticks"}, q_tick.size(), NB);
      if (q_tick.size() == NB) begin
         for (int k = 0; k < NB; k++)
            chk($sformatf("%s_ttick%0d", nm, k), q_tick[k], t0 + 15 + 16 * k);
         chk({nm, "_startbit"}, q_bit[0], 0);
         for (int i = 0; i < 8; i++) b[i] = q_bit[i+1];
         chk({nm, "_byte"}, b, exp_byte);
         chk({nm, "_stopbit"}, q_bit[NB-1], exp_stop);
      end
      chk({nm, "_nferr"}, q_ferr.size(), exp_ferr);
      if (exp_ferr && q_ferr.size() > 0) chk({nm, "_tferr"}, q_ferr[0], t0 + 159);
      chk({nm, "_nfall"}, q_fall.size(), 1);
      if (q_fall.size() > 0) chk({nm, "_tfall"}, q_fall[0], t0 + 160);
      clear_q();
   endtask

   initial begin : stim
      int c0;
      logic [7:0] b;
      rst = 1'b1; ena = 1'b0; ir_n = 1'b1;
      repeat (4) @(negedge clk);
      #3;
      chk("rst_start", start, 0);
      chk("rst_baud_rxir", baud_rxir, 0);
      chk("rst_rx_bit", rx_bit, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0; ena = 1'b1;
      repeat (5) @(negedge clk);
      clear_q();

      // Alternating byte
      wave_clear(); wave_frame(0, 8'h55, 1'b0);
      play(180, -1, -1, 0, c0);
      check_frame("b55", c0, 8'h55, 1'b1, 1'b0);

      // Single-cycle glitch must be ignored
      wave_clear(); wave_pulse(0, 1);
      play(30, -1, -1, 0, c0);
      chk("glitch_nstart", q_start.size(), 0);
      chk("glitch_nticks", q_tick.size(), 0);
      chk("glitch_nfall", q_fall.size(), 0);
      clear_q();

      // All-zero byte
      wave_clear(); wave_frame(0, 8'h00, 1'b0);
      play(180, -1, -1, 0, c0);
      check_frame("b00", c0, 8'h00, 1'b1, 1'b0);

      // All-ones byte with a pulse in the stop window
      wave_clear(); wave_frame(0, 8'hFF, 1'b1);
      play(180, -1, -1, 0, c0);
      check_frame("stop_err", c0, 8'hFF, 1'b0, 1'b1);

      // Pulse accepted on tick 1: window 1 reads 1, window 2 reads 0
      wave_clear(); wave_pulse(0, 3); wave_pulse(30, 3);
      play(180, -1, -1, 0, c0);
      check_frame("on_tick", c0, 8'hFD, 1'b1, 1'b0);

      // Reset at T0+40, fresh frame starting T0+60
      wave_clear(); wave_pulse(0, 3); wave_pulse(32, 3); wave_frame(60, 8'h55, 1'b0);
      play(240, 42, -1, 0, c0);
      chk("rst_mid_nstart", q_start.size(), 2);
      if (q_start.size() == 2) chk("rst_mid_tstart2", q_start[1], c0 + 63);
      chk("rst_mid_nticks", q_tick.size(), 12);
      if (q_tick.size() == 12) begin
         chk("rst_mid_ttick1", q_tick[1], c0 + 33);
         chk("rst_mid_ttick2", q_tick[2], c0 + 77);
         for (int i = 0; i < 8; i++) b[i] = q_bit[i+3];
         chk("rst_mid_byte", b, 8'h55);
      end
      chk("rst_mid_nfall", q_fall.size(), 2);
      if (q_fall.size() == 2) begin
         chk("rst_mid_tfall1", q_fall[0], c0 + 43);
         chk("rst_mid_tfall2", q_fall[1], c0 + 222);
      end
      clear_q();

      // ena low for 20 cycles mid-frame; line stuck low across re-enable
      wave_clear(); wave_pulse(0, 3); wave_pulse(50, 30); wave_frame(100, 8'hA3, 1'b0);
      play(280, -1, 40, 20, c0);
      chk("ena_nstart", q_start.size(), 2);
      if (q_start.size() == 2) chk("ena_tstart2", q_start[1], c0 + 103);
      chk("ena_nticks", q_tick.size(), 12);
      if (q_tick.size() == 12) begin
         chk("ena_ttick1", q_tick[1], c0 + 33);
         chk("ena_ttick2", q_tick[2], c0 + 117);
         for (int i = 0; i < 8; i++) b[i] = q_bit[i+3];
         chk("ena_byte", b, 8'hA3);
      end
      chk("ena_nfall", q_fall.size(), 2);
      if (q_fall.size() == 2) chk("ena_tfall1", q_fall[0], c0 + 41);
      clear_q();

      repeat (5) @(negedge clk);
      #4;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule : tb_irda_rx_demod
